// File: rtl/mul_opq_mac.sv
// Peripheral-bus multiply-accumulate engine: operand pairs are queued in a small FIFO
// and a 16-cycle shift-add unit folds each 32-bit product into a 40-bit accumulator.
module mul_opq_mac #(
   parameter logic [13:0] BASE_ADDR = 14'h0A8,
   parameter int          DEPTH     = 4
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ACC} state_t;

   state_t          state_q, state_d;
   logic [15:0]     opa_q, opa_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [39:0]     acc_q, acc_d;
   logic [31:0]     prod_q, prod_d;
   logic [15:0]     mcand_q, mcand_d, mplier_q, mplier_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [31:0]     mem_q [DEPTH];

   // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both bounds.
   logic [13:0] offs;
   logic        sel, wr_en, rd_en;
   logic        wr_opa, wr_opb, wr_ctl;
   logic        ctl_clr, ctl_clrovf, ctl_flush;
   logic        empty, full, busy, push, pop, acc_upd;
   logic [31:0] head;

   assign offs       = per_addr - BASE_ADDR;
   assign sel        = per_en & (offs < 14'd6);
   assign wr_en      = sel & (per_we == 2'b11);
   assign rd_en      = sel & (per_we == 2'b00);
   assign wr_opa     = wr_en & (offs[2:0] == 3'd0);
   assign wr_opb     = wr_en & (offs[2:0] == 3'd1);
   assign wr_ctl     = wr_en & (offs[2:0] == 3'd2);
   assign ctl_clr    = wr_ctl & per_din[0];
   assign ctl_clrovf = wr_ctl & per_din[1];
   assign ctl_flush  = wr_ctl & per_din[2];

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign busy    = (state_q != ST_IDLE) | ~empty;
   assign push    = wr_opb & ~full & ~ctl_flush;
   assign pop     = (state_q == ST_IDLE) & ~empty & ~ctl_flush;
   assign acc_upd = (state_q == ST_ACC) & ~ctl_flush;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      bitcnt_d = bitcnt_q;

      if (wr_opa) opa_d = per_din;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (wr_opb & full)   ovf_d = 1'b1;
      else if (ctl_clrovf) ovf_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               mcand_d  = head[31:16];
               mplier_d = head[15:0];
               prod_d   = '0;
               bitcnt_d = '0;
               state_d  = ST_MUL;
            end
         end
         ST_MUL: begin
            if (mplier_q[0]) prod_d = prod_q + ({16'h0, mcand_q} << bitcnt_q);
            mplier_d = mplier_q >> 1;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd15) state_d = ST_ACC;
         end
         ST_ACC:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Clear happens before the add, so a coinciding product survives the clear.
      if (ctl_clr)      acc_d = acc_upd ? {8'h0, prod_q} : 40'h0;
      else if (acc_upd) acc_d = acc_q + {8'h0, prod_q};

      if (ctl_flush) begin
         state_d  = ST_IDLE;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         prod_d   = '0;
         mplier_d = '0;
         bitcnt_d = '0;
      end
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         bitcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   // Storage carries no reset; emptiness is defined solely by the pointers and count.
   always_ff @(posedge mclk) begin
      if (push) mem_q[wr_ptr_q] <= {opa_q, per_din};
   end

   always_comb begin
      per_dout = 16'h0;
      if (rd_en) begin
         case (offs[2:0])
            3'd2:    per_dout = {4'b0, 4'(count_q), 4'b0, ovf_q, busy, full, empty};
            3'd3:    per_dout = acc_q[15:0];
            3'd4:    per_dout = acc_q[31:16];
            3'd5:    per_dout = {8'h0, acc_q[39:32]};
            default: per_dout = 16'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_opq_mac.sv
// Scoreboard bench for mul_opq_mac: accepted pushes queue their expected product,
// which is folded into a model accumulator once the engine has drained.
module tb_mul_opq_mac;

   localparam logic [13:0] A_OPA  = 14'h0A8;
   localparam logic [13:0] A_OPB  = 14'h0A9;
   localparam logic [13:0] A_CTL  = 14'h0AA;
   localparam logic [13:0] A_ACCL = 14'h0AB;
   localparam logic [13:0] A_ACCH = 14'h0AC;
   localparam logic [13:0] A_ACCX = 14'h0AD;
   localparam logic [13:0] A_UNM  = 14'h0AE;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic [39:0] model_acc;
   logic [15:0] opa_model;
   logic [15:0] rdat;

   always #5 mclk = ~mclk;

   mul_opq_mac #(.BASE_ADDR(14'h0A8), .DEPTH(4)) dut (
      .mclk     (mclk),
      .puc_rst  (puc_rst),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_en   (per_en),
      .per_we   (per_we),
      .per_dout (per_dout)
   );

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic bus_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
      per_en   = 1'b1;
      per_we   = we;
      per_addr = a;
      per_din  = d;
      @(posedge mclk);
      #1;
      per_en = 1'b0;
      per_we = 2'b00;
   endtask

   task automatic bus_rd(input logic [13:0] a, output logic [15:0] d);
      per_en   = 1'b1;
      per_we   = 2'b00;
      per_addr = a;
      #1;
      d = per_dout;
      @(posedge mclk);
      #1;
      per_en = 1'b0;
   endtask

   task automatic set_opa(input logic [15:0] a);
      bus_wr(A_OPA, a, 2'b11);
      opa_model = a;
   endtask

   task automatic push_opb(input logic [15:0] b, input bit accepted);
      bus_wr(A_OPB, b, 2'b11);
      if (accepted) exp_q.push_back(32'(opa_model) * 32'(b));
   endtask

   task automatic clear_acc();
      bus_wr(A_CTL, 16'h0001, 2'b11);
      model_acc = '0;
   endtask

   task automatic wait_idle();
      logic [15:0] s;
      bit          done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         bus_rd(A_CTL, s);
         if (!s[2]) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 40'd0, 40'd1);
   endtask

   task automatic check_acc(input string tag);
      logic [15:0] lo, hi, x;
      while (exp_q.size() > 0) model_acc = model_acc + {8'h0, exp_q.pop_front()};
      bus_rd(A_ACCL, lo);
      bus_rd(A_ACCH, hi);
      bus_rd(A_ACCX, x);
      chk({tag, "_lo"}, {24'h0, lo}, {24'h0, model_acc[15:0]});
      chk({tag, "_hi"}, {24'h0, hi}, {24'h0, model_acc[31:16]});
      chk({tag, "_x"},  {24'h0, x},  {32'h0, model_acc[39:32]});
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      puc_rst   = 1'b1;
      per_en    = 1'b0;
      per_we    = 2'b00;
      per_addr  = '0;
      per_din   = '0;
      model_acc = '0;
      opa_model = '0;
      repeat (3) @(posedge mclk);
      #1;
      puc_rst = 1'b0;

      // Reset state
      bus_rd(A_CTL, rdat);
      chk("rst_stat", {24'h0, rdat}, 40'h0001);
      check_acc("rst_acc");
      bus_rd(A_UNM, rdat);
      chk("unmapped_rd", {24'h0, rdat}, 40'h0);
      bus_rd(A_OPA, rdat);
      chk("opa_wo_rd", {24'h0, rdat}, 40'h0);

      // 3 x 5 latency: still zero 17 edges after the push, valid on the 18th
      set_opa(16'd3);
      push_opb(16'd5, 1'b1);
      repeat (17) @(posedge mclk);
      #1;
      bus_rd(A_ACCL, rdat);
      chk("lat17_lo", {24'h0, rdat}, 40'h0);
      check_acc("lat18");
      bus_rd(A_CTL, rdat);
      chk("lat18_stat", {24'h0, rdat}, 40'h0001);

      // Four maximal products
      clear_acc();
      set_opa(16'hFFFF);
      for (int i = 0; i < 4; i++) push_opb(16'hFFFF, 1'b1);
      wait_idle();
      check_acc("max4");

      // Overflow: 6 back-to-back pushes, the sixth finds 4 entries queued
      clear_acc();
      set_opa(16'd1);
      for (int i = 1; i <= 6; i++) push_opb(16'(i), i <= 5);
      wait_idle();
      bus_rd(A_CTL, rdat);
      chk("ovf_stat", {24'h0, rdat}, 40'h0009);
      check_acc("ovf_acc");
      bus_wr(A_CTL, 16'h0002, 2'b11);
      bus_rd(A_CTL, rdat);
      chk("clrovf_stat", {24'h0, rdat}, 40'h0001);

      // Flush during the first multiply discards everything
      clear_acc();
      set_opa(16'd1);
      for (int i = 0; i < 3; i++) push_opb(16'd7, 1'b1);
      bus_wr(A_CTL, 16'h0004, 2'b11);
      exp_q.delete();
      bus_rd(A_CTL, rdat);
      chk("flush_stat", {24'h0, rdat}, 40'h0001);
      repeat (40) @(posedge mclk);
      #1;
      check_acc("flush_acc");

      // Byte write to OPB is ignored
      bus_wr(A_OPB, 16'd9, 2'b01);
      bus_rd(A_CTL, rdat);
      chk("bytewr_stat", {24'h0, rdat}, 40'h0001);
      repeat (20) @(posedge mclk);
      #1;
      check_acc("bytewr_acc");

      // Seed acc with 7, then CLR on the same edge as the 2 x 3 accumulate
      push_opb(16'd7, 1'b1);
      wait_idle();
      check_acc("seed7");
      set_opa(16'd2);
      push_opb(16'd3, 1'b1);
      repeat (17) @(posedge mclk);
      #1;
      bus_wr(A_CTL, 16'h0001, 2'b11);
      model_acc = '0;
      check_acc("clr_acc_same");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
